// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM states, matrix size
// and the row/column to key-code mapping.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    SCAN,
    DB_PRESS,
    HELD,
    DB_RELEASE
  } state_e;

  function automatic logic [3:0] key_code(input logic [1:0] row_idx,
                                          input logic [1:0] col_idx);
    return 4'(int'(row_idx) * NUM_COLS + int'(col_idx));
  endfunction

  // Lowest-index active-low row wins when several rows are pulled low.
  function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_if.sv
// Handshake between the scanner FSM and the shared debounce counter.
interface keypad_if;

  logic match;
  logic clear;
  logic done;

  modport master (output match, output clear, input done);
  modport slave  (input match, input clear, output done);

endinterface

// File: rtl/keypad_debounce.sv
// Counts consecutive matching cycles; done fires combinationally on the
// cycle that completes DEBOUNCE_CYCLES matches so the FSM can act at once.
module keypad_debounce #(
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input  logic     clk,
  input  logic     rst,
  keypad_if.slave  db
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_last;

  // The counter holds DEBOUNCE_CYCLES-1 at most; the final match is the done cycle.
  always_comb begin
    at_last = (cnt_q == CNT_LAST);
    cnt_d   = cnt_q;
    if (db.clear || !db.match) begin
      cnt_d = '0;
    end else if (!at_last) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign db.done = db.match && !db.clear && at_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks the columns, debounces one key at a time
// and reports its code with a held flag whose falling edge ends a keypress.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input  logic       hwclk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] button,
  output logic       bstate
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [3:0]       row_s1_q, row_s2_q;
  state_e           state_q, state_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       button_q, button_d;
  logic             bstate_q, bstate_d;
  logic [3:0]       press_pattern;

  keypad_if db_if ();

  keypad_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk (hwclk),
    .rst (rst),
    .db  (db_if)
  );

  assign press_pattern = ~(4'b0001 << row_idx_q);
  assign db_if.clear   = (state_q == SCAN) || (state_q == HELD);
  assign db_if.match   = (state_q == DB_PRESS) ? (row_s2_q == press_pattern)
                                               : (row_s2_q == 4'hF);

  assign col    = ~(4'b0001 << col_idx_q);
  assign button = button_q;
  assign bstate = bstate_q;

  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    row_idx_d = row_idx_q;
    div_d     = div_q;
    button_d  = button_q;
    bstate_d  = bstate_q;
    case (state_q)
      SCAN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (row_s2_q == 4'hF) begin
            col_idx_d = col_idx_q + 1'b1;
          end else begin
            row_idx_d = lowest_low_row(row_s2_q);
            state_d   = DB_PRESS;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      DB_PRESS: begin
        if (!db_if.match) begin
          state_d = SCAN;
          div_d   = '0;
        end else if (db_if.done) begin
          state_d  = HELD;
          button_d = key_code(row_idx_q, col_idx_q);
          bstate_d = 1'b1;
        end
      end
      HELD: begin
        if (row_s2_q == 4'hF) state_d = DB_RELEASE;
      end
      DB_RELEASE: begin
        // A key that returns mid-release goes back to HELD without a new code.
        if (!db_if.match) begin
          state_d = HELD;
        end else if (db_if.done) begin
          state_d   = SCAN;
          bstate_d  = 1'b0;
          col_idx_d = col_idx_q + 1'b1;
          div_d     = '0;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      row_s1_q  <= 4'hF;
      row_s2_q  <= 4'hF;
      state_q   <= SCAN;
      col_idx_q <= 2'd0;
      row_idx_q <= 2'd0;
      div_q     <= '0;
      button_q  <= 4'h0;
      bstate_q  <= 1'b0;
    end else begin
      row_s1_q  <= row;
      row_s2_q  <= row_s1_q;
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      row_idx_q <= row_idx_d;
      div_q     <= div_d;
      button_q  <= button_d;
      bstate_q  <= bstate_d;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a keypad matrix model drives row
// from the pressed keys and col; a behavioural model is compared every cycle.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DB       = 8;

  typedef enum {M_SCANNING, M_PRESSING, M_HOLDING, M_RELEASING} mphase_t;

  logic        hwclk = 1'b0;
  logic        rst;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  button;
  logic        bstate;
  logic [15:0] keys;

  int checks = 0;
  int errors = 0;
  int rises  = 0;
  logic prev_bstate = 1'b0;

  mphase_t    m_phase;
  int         m_col, m_tick, m_row, m_run, m_button;
  logic       m_bstate;
  logic [3:0] sync_q[$];

  keypad_scanner #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .hwclk  (hwclk),
    .rst    (rst),
    .row    (row),
    .col    (col),
    .button (button),
    .bstate (bstate)
  );

  always #5 hwclk = ~hwclk;

  // A row is pulled low when any pressed key on it sits in the driven column.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      row[r] = ~|(keys[r*4 +: 4] & ~col);
    end
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_phase  = M_SCANNING;
    m_col    = 0;
    m_tick   = 0;
    m_row    = 0;
    m_run    = 0;
    m_button = 0;
    m_bstate = 1'b0;
    sync_q   = '{4'hF, 4'hF};
  endtask

  // One clock of the reference behaviour; the decision uses the row seen two clocks ago.
  task automatic model_step(input logic [3:0] raw);
    logic [3:0] seen;
    logic [3:0] want;
    bit found;
    seen = sync_q.pop_front();
    sync_q.push_back(raw);
    case (m_phase)
      M_SCANNING: begin
        m_tick++;
        if (m_tick == SCAN_DIV) begin
          m_tick = 0;
          if (seen == 4'hF) begin
            m_col = (m_col + 1) % 4;
          end else begin
            found = 0;
            for (int r = 0; r < 4; r++) begin
              if (!found && !seen[r]) begin
                m_row = r;
                found = 1;
              end
            end
            m_run   = 0;
            m_phase = M_PRESSING;
          end
        end
      end
      M_PRESSING: begin
        want = 4'hF;
        want[m_row] = 1'b0;
        if (seen == want) begin
          m_run++;
          if (m_run == DB) begin
            m_button = m_row * 4 + m_col;
            m_bstate = 1'b1;
            m_phase  = M_HOLDING;
          end
        end else begin
          m_tick  = 0;
          m_phase = M_SCANNING;
        end
      end
      M_HOLDING: begin
        if (seen == 4'hF) begin
          m_run   = 0;
          m_phase = M_RELEASING;
        end
      end
      M_RELEASING: begin
        if (seen == 4'hF) begin
          m_run++;
          if (m_run == DB) begin
            m_bstate = 1'b0;
            m_col    = (m_col + 1) % 4;
            m_tick   = 0;
            m_phase  = M_SCANNING;
          end
        end else begin
          m_phase = M_HOLDING;
        end
      end
      default: m_phase = M_SCANNING;
    endcase
  endtask

  // Compare at the falling edge, then advance the model for the coming rising edge.
  task automatic tick();
    logic [3:0] want_col;
    @(negedge hwclk);
    if (rst) model_reset();
    want_col = 4'hF;
    want_col[m_col] = 1'b0;
    check("col", 32'(col), 32'(want_col));
    check("button", 32'(button), 32'(m_button));
    check("bstate", 32'(bstate), 32'(m_bstate));
    if (bstate === 1'b1 && prev_bstate === 1'b0) rises++;
    prev_bstate = bstate;
    if (!rst) model_step(row);
    @(posedge hwclk);
    #1;
  endtask

  task automatic wait_col(input logic [3:0] want);
    int n;
    n = 0;
    while (col !== want && n < 40) begin
      tick();
      n++;
    end
    check("wait_col", 32'(col), 32'(want));
  endtask

  initial begin
    int base, kind, len, k;
    rst  = 1'b1;
    keys = '0;
    repeat (3) tick();
    check("reset_col", 32'(col), 32'hE);
    check("reset_button", 32'(button), 32'h0);
    check("reset_bstate", 32'(bstate), 32'h0);
    rst = 1'b0;

    for (int c = 1; c <= 16; c++) begin
      tick();
      case (c)
        3:  check("idle_col_c0", 32'(col), 32'hE);
        4:  check("idle_col_c1", 32'(col), 32'hD);
        8:  check("idle_col_c2", 32'(col), 32'hB);
        12: check("idle_col_c3", 32'(col), 32'h7);
        16: check("idle_col_wrap", 32'(col), 32'hE);
        default: ;
      endcase
    end

    // Key 6 (row 1, column 2): single clean press and release.
    base = rises;
    wait_col(4'b1011);
    keys[6] = 1'b1;
    repeat (30) tick();
    check("k6_bstate_held", 32'(bstate), 32'h1);
    check("k6_button", 32'(button), 32'h6);
    keys[6] = 1'b0;
    repeat (10) tick();
    check("k6_bstate_before_release", 32'(bstate), 32'h1);
    tick();
    check("k6_bstate_released", 32'(bstate), 32'h0);
    check("k6_button_after_release", 32'(button), 32'h6);
    repeat (20) tick();
    check("k6_single_pulse", 32'(rises - base), 32'h1);

    // Key 13 (row 3, column 1) bounces before settling.
    base = rises;
    wait_col(4'b1101);
    for (int i = 0; i < 7; i++) begin
      keys[13] = (i % 2 == 0);
      repeat (3) tick();
    end
    keys[13] = 1'b1;
    repeat (40) tick();
    check("bounce_bstate", 32'(bstate), 32'h1);
    check("bounce_button", 32'(button), 32'hD);
    keys[13] = 1'b0;
    repeat (30) tick();
    check("bounce_released", 32'(bstate), 32'h0);
    check("bounce_single_pulse", 32'(rises - base), 32'h1);

    // Second key in another column while key 6 is held.
    base = rises;
    wait_col(4'b1011);
    keys[6] = 1'b1;
    repeat (30) tick();
    keys[0] = 1'b1;
    repeat (20) tick();
    check("two_key_button", 32'(button), 32'h6);
    check("two_key_bstate", 32'(bstate), 32'h1);
    keys[0] = 1'b0;
    repeat (5) tick();
    keys[6] = 1'b0;
    repeat (30) tick();
    check("two_key_released", 32'(bstate), 32'h0);
    check("two_key_button_kept", 32'(button), 32'h6);
    check("two_key_single_pulse", 32'(rises - base), 32'h1);

    // Reset while held, then re-acceptance of the still-pressed key.
    base = rises;
    wait_col(4'b1011);
    keys[6] = 1'b1;
    repeat (30) tick();
    check("rst_pre_bstate", 32'(bstate), 32'h1);
    #1 rst = 1'b1;
    #1;
    check("rst_async_bstate", 32'(bstate), 32'h0);
    check("rst_async_col", 32'(col), 32'hE);
    check("rst_async_button", 32'(button), 32'h0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (15) tick();
    check("rst_debouncing", 32'(bstate), 32'h0);
    repeat (25) tick();
    check("rst_reaccept_bstate", 32'(bstate), 32'h1);
    check("rst_reaccept_button", 32'(button), 32'h6);
    check("rst_reaccept_rises", 32'(rises - base), 32'h2);
    keys[6] = 1'b0;
    repeat (30) tick();

    // Randomised presses, multi-key chords, bounces and the odd reset.
    for (int seg = 0; seg < 60; seg++) begin
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 45);
      if (kind < 4) begin
        keys = '0;
        keys[$urandom_range(0, 15)] = 1'b1;
        repeat (len) tick();
      end else if (kind < 6) begin
        keys = '0;
        repeat (len) tick();
      end else if (kind < 8) begin
        keys[$urandom_range(0, 15)] = 1'b1;
        repeat (len) tick();
      end else begin
        k = $urandom_range(0, 15);
        for (int i = 0; i < len; i++) begin
          if ($urandom_range(0, 2) == 0) keys[k] = ~keys[k];
          tick();
        end
      end
      if (seg % 20 == 19) begin
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
      end
    end
    keys = '0;
    repeat (40) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, meaning clock cycles each column is driven before its rows are sampled (minimum 2).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 200000, meaning consecutive stable samples required to accept a press or a release (minimum 1).
REQ-003 SHALL have port hwclk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port row, input, 4 bits: keypad row lines, active-low with external pull-ups, asynchronous to hwclk.
REQ-006 SHALL have port col, output, 4 bits: keypad column drive, active-low one-hot; exactly one bit low at all times out of reset.
REQ-007 SHALL have port button, output, 4 bits: code of the accepted key, equal to row_index*4 + col_index (0..15).
REQ-008 SHALL have port bstate, output, 1 bit: high while an accepted key is held; its falling edge marks a completed keypress for the downstream code checker.

Function
REQ-009 SHALL pass row through a two-flop synchronizer; all decisions use the synchronized value only (2-cycle input latency).
REQ-010 SHALL implement FSM states SCAN, DB_PRESS, HELD and DB_RELEASE.
REQ-011 SCAN: SHALL drive col[c] low for SCAN_DIV cycles, sampling synchronized row on the last cycle; if all rows are high, advance c by one, wrapping 3->0.
REQ-012 SCAN: on a sample with any row low, SHALL latch the lowest-index low row r, hold column c, and enter DB_PRESS.
REQ-013 DB_PRESS: SHALL count cycles in which the synchronized row equals the latched one-hot pattern; any mismatch returns to SCAN at the same column with the counter cleared.
REQ-014 DB_PRESS: when the count reaches DEBOUNCE_CYCLES, SHALL enter HELD; in the same cycle load button with r*4+c and assert bstate.
REQ-015 HELD: bstate SHALL stay high; when the synchronized row is all high, SHALL enter DB_RELEASE with the counter cleared.
REQ-016 DB_RELEASE: SHALL count consecutive all-high cycles; any low row returns to HELD (bstate remains high, no new code).
REQ-017 DB_RELEASE: when the count reaches DEBOUNCE_CYCLES, SHALL deassert bstate, enter SCAN, and advance to column (c+1) mod 4.
REQ-018 SHALL keep button unchanged from acceptance until the next acceptance, so it is stable on and after the bstate falling edge.
REQ-019 Second key pressed while HELD or DB_RELEASE: SHALL ignore it; only the latched row/column is observed; it produces no code.
REQ-020 Multiple rows low at the SCAN sample: SHALL take the lowest index; DB_PRESS then fails on the pattern mismatch until only one row remains low.
REQ-021 Counters SHALL be sized with $clog2 of their parameter and SHALL saturate, never wrap.

Reset
REQ-022 On rst SHALL enter SCAN immediately: column 0, col=4'b1110, button=4'h0, bstate=0, counters and synchronizer cleared to idle (row flops = 4'hF).
REQ-023 Reset asserted while HELD SHALL drop bstate without a debounce period; downstream treats the resulting edge as a reset artefact.

Structure
REQ-024 Package keypad_pkg SHALL hold the FSM state enum, the row/column count (4), and the key-code mapping function.
REQ-025 A sub-module keypad_debounce (match input, clear input, DEBOUNCE_CYCLES counter, done output) SHALL be instantiated once and shared by DB_PRESS and DB_RELEASE.

Verification (SCAN_DIV=4, DEBOUNCE_CYCLES=8)
REQ-026 Reset, no key: col cycles 1110->1101->1011->0111->1110, 4 cycles each; bstate stays 0.
REQ-027 Hold row=4'b1101 during the col=4'b1011 window for 30 cycles, then release for 30 cycles: button=4'h6, bstate high from acceptance until 8 cycles plus sync latency after release, then falls once.
REQ-028 Bounce: row toggles low/high every 3 cycles for 20 cycles, then stays low: exactly one acceptance, with no bstate glitch during the bounce.
REQ-029 While key 6 is held, also press row 0 in column 0: button stays 4'h6 and there is a single bstate pulse.
REQ-030 Assert rst while HELD: bstate=0 and col=4'b1110 within the same cycle; after rst is released, the still-held key is re-accepted after a full debounce.
